// File: rtl/psum_gather_ctrl.sv
// psum_gather_ctrl: round-robin gather of one PE row's partial sums into a tagged first-word-fall-through FIFO
module psum_gather_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int NUM_ROW    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = 2*DATA_WIDTH,
  localparam int RW         = $clog2(NUM_ROW),
  localparam int CW         = $clog2(NUM_COL),
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int KW         = AW+1
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  output logic                  rst_busy,
  input  logic [RW-1:0]         row_id_in,
  input  logic [NUM_COL*PW-1:0] pe_psum_data_M2B,
  input  logic [NUM_COL-1:0]    pe_psum_valid_M2B,
  output logic [NUM_COL-1:0]    pe_psum_ready_B2M,
  output logic [PW-1:0]         psum_data_B2G,
  output logic [RW-1:0]         psum_row_B2G,
  output logic [CW-1:0]         psum_col_B2G,
  output logic                  psum_valid_B2G,
  input  logic                  psum_ready_G2B,
  output logic [KW-1:0]         fifo_count
);
  localparam int IW = CW+1;
  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [PW-1:0] data;
  } ent_t;
  ent_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [KW-1:0] r_count;
  logic [CW-1:0] r_rr;
  logic [RW-1:0] r_row;
  logic          r_busy;
  logic          w_full, w_empty, w_found, w_push, w_pop;
  logic [CW-1:0] w_gidx;
  logic [IW-1:0] w_idx;
  ent_t          w_head;
  assign w_full            = r_count == KW'(FIFO_DEPTH);
  assign w_empty           = r_count == '0;
  assign w_push            = w_found && !w_full && !flush && !r_busy;
  assign w_pop             = !w_empty && psum_ready_G2B && !flush;
  assign pe_psum_ready_B2M = w_push ? ({{(NUM_COL-1){1'b0}}, 1'b1} << w_gidx) : '0;
  assign w_head            = r_mem[r_rd];
  assign psum_data_B2G     = w_head.data;
  assign psum_row_B2G      = w_head.row;
  assign psum_col_B2G      = w_head.col;
  assign psum_valid_B2G    = !w_empty;
  assign fifo_count        = r_count;
  assign rst_busy          = r_busy;
  // first valid PE searching upward from r_rr, wrapping at NUM_COL
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      w_idx = IW'(r_rr) + IW'(k);
      w_idx = (w_idx >= IW'(NUM_COL)) ? w_idx - IW'(NUM_COL) : w_idx;
      if (!w_found && pe_psum_valid_M2B[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[CW-1:0];
      end
    end
  end
  // busy for the cycle following reset release or any flush cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_busy <= 1'b1;
    else       r_busy <= flush;
  // FIFO pointers, occupancy, arbiter pointer and latched row tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_rr    <= '0;
      r_row   <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_rr    <= '0;
      r_row   <= row_id_in;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
        r_rr <= (w_gidx == CW'(NUM_COL-1)) ? '0 : w_gidx + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + KW'(w_push) - KW'(w_pop);
    end
  end
  // entry storage needs no reset: only written slots are ever presented as valid
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= '{row: r_row, col: w_gidx, data: pe_psum_data_M2B[w_gidx*PW +: PW]};
endmodule

// File: tb/tb_psum_gather_ctrl.sv
// tb_psum_gather_ctrl: directed vector table, reset corners and randomized traffic against a queue model
module tb_psum_gather_ctrl;
  localparam int DW = 16, NC = 4, NR = 4, FD = 4;
  localparam int PW = 2*DW, RW = 2, CW = 2, KW = 3;
  logic             clk = 1'b0;
  logic             rstn, flush, rst_busy, o_valid, g_ready;
  logic [RW-1:0]    row_id_in, o_row;
  logic [NC*PW-1:0] pe_data;
  logic [NC-1:0]    pe_valid, pe_ready;
  logic [PW-1:0]    o_data;
  logic [CW-1:0]    o_col;
  logic [KW-1:0]    fifo_count;
  always #5 clk = ~clk;
  psum_gather_ctrl #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .rst_busy(rst_busy), .row_id_in(row_id_in),
    .pe_psum_data_M2B(pe_data), .pe_psum_valid_M2B(pe_valid), .pe_psum_ready_B2M(pe_ready),
    .psum_data_B2G(o_data), .psum_row_B2G(o_row), .psum_col_B2G(o_col),
    .psum_valid_B2G(o_valid), .psum_ready_G2B(g_ready), .fifo_count(fifo_count)
  );
  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [PW-1:0] data;
  } ent_t;
  typedef struct {
    logic fl; logic [RW-1:0] rid; logic [NC-1:0] v; logic gr;
    logic [NC-1:0] rdy; logic vld; logic [CW-1:0] col; logic [RW-1:0] row; int cnt; logic busy;
  } vec_t;
  ent_t          q[$];
  int            rr;
  logic [RW-1:0] mrow;
  bit            mbusy;
  int            vectors = 0, miscompares = 0;
  vec_t          tbl[26];
  logic [NC-1:0] pend;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic fl, logic [RW-1:0] rid, logic [NC-1:0] v, logic gr,
                              logic [NC-1:0] rdy, logic vld, logic [CW-1:0] col, logic [RW-1:0] row, int cnt, logic busy);
    vec_t t;
    t.fl = fl; t.rid = rid; t.v = v; t.gr = gr; t.rdy = rdy; t.vld = vld; t.col = col; t.row = row; t.cnt = cnt; t.busy = busy;
    return t;
  endfunction
  function automatic int mgrant(logic fl, logic [NC-1:0] v);
    if (fl || mbusy || q.size() >= FD) return -1;
    for (int k = 0; k < NC; k++) if (v[(rr+k)%NC]) return (rr+k)%NC;
    return -1;
  endfunction
  task automatic mreset();
    q.delete();
    rr = 0;
    mrow = '0;
    mbusy = 1'b1;
  endtask
  task automatic drive(input logic fl, input logic [RW-1:0] rid, input logic [NC-1:0] v, input logic gr);
    flush = fl;
    row_id_in = rid;
    pe_valid = v;
    g_ready = gr;
    #1;
  endtask
  task automatic advance();
    int   g;
    bit   pop;
    ent_t e;
    g = mgrant(flush, pe_valid);
    pop = q.size() > 0 && g_ready;
    @(posedge clk);
    if (flush) begin
      q.delete();
      rr = 0;
      mrow = row_id_in;
      mbusy = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        e.row = mrow;
        e.col = CW'(g);
        e.data = pe_data[g*PW +: PW];
        q.push_back(e);
        rr = (g+1) % NC;
      end
      mbusy = 1'b0;
    end
    @(negedge clk);
  endtask
  task automatic mcheck();
    int g;
    g = mgrant(flush, pe_valid);
    chk("ready", 64'(pe_ready), (g < 0) ? 64'd0 : 64'd1 << g);
    chk("valid", 64'(o_valid), 64'(q.size() > 0));
    chk("count", 64'(fifo_count), 64'(q.size()));
    chk("busy", 64'(rst_busy), 64'(mbusy));
    if (q.size() > 0) begin
      chk("data", 64'(o_data), 64'(q[0].data));
      chk("row", 64'(o_row), 64'(q[0].row));
      chk("col", 64'(o_col), 64'(q[0].col));
    end
  endtask
  initial begin
    tbl[0]  = mk(1, 2, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 4'b1110, 1, 4'b0010, 1, 0, 2, 1, 0);
    tbl[4]  = mk(0, 0, 4'b1100, 1, 4'b0100, 1, 1, 2, 1, 0);
    tbl[5]  = mk(0, 0, 4'b1000, 1, 4'b1000, 1, 2, 2, 1, 0);
    tbl[6]  = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 3, 2, 1, 0);
    tbl[7]  = mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 4'b0101, 1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 4'b0101, 1, 4'b0100, 1, 0, 2, 1, 0);
    tbl[10] = mk(0, 0, 4'b0101, 1, 4'b0001, 1, 2, 2, 1, 0);
    tbl[11] = mk(0, 0, 4'b0101, 1, 4'b0100, 1, 0, 2, 1, 0);
    tbl[12] = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 2, 2, 1, 0);
    tbl[13] = mk(0, 0, 4'b1111, 0, 4'b1000, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 4'b1111, 0, 4'b0001, 1, 3, 2, 1, 0);
    tbl[15] = mk(0, 0, 4'b1111, 0, 4'b0010, 1, 3, 2, 2, 0);
    tbl[16] = mk(0, 0, 4'b1111, 0, 4'b0100, 1, 3, 2, 3, 0);
    tbl[17] = mk(0, 0, 4'b1111, 0, 4'b0000, 1, 3, 2, 4, 0);
    tbl[18] = mk(0, 0, 4'b1111, 1, 4'b0000, 1, 3, 2, 4, 0);
    tbl[19] = mk(0, 0, 4'b1111, 0, 4'b1000, 1, 0, 2, 3, 0);
    tbl[20] = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 2, 4, 0);
    tbl[21] = mk(1, 1, 4'b1111, 1, 4'b0000, 1, 1, 2, 3, 0);
    tbl[22] = mk(0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, 1);
    tbl[23] = mk(0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 1, 1, 0);
    tbl[25] = mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    flush = 1'b0;
    row_id_in = '0;
    pe_valid = '0;
    g_ready = 1'b0;
    for (int i = 0; i < NC; i++) pe_data[i*PW +: PW] = PW'(32'h10 + i);
    mreset();
    repeat (2) @(negedge clk);
    pe_valid = '1;
    #1;
    chk("reset busy", 64'(rst_busy), 64'd1);
    chk("reset ready", 64'(pe_ready), 64'd0);
    chk("reset valid", 64'(o_valid), 64'd0);
    chk("reset count", 64'(fifo_count), 64'd0);
    rstn = 1'b1;
    #1;
    chk("release busy", 64'(rst_busy), 64'd1);
    chk("release ready", 64'(pe_ready), 64'd0);
    advance();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].fl, tbl[i].rid, tbl[i].v, tbl[i].gr);
      chk($sformatf("vec%0d ready", i), 64'(pe_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d valid", i), 64'(o_valid), 64'(tbl[i].vld));
      chk($sformatf("vec%0d count", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d busy", i), 64'(rst_busy), 64'(tbl[i].busy));
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d col", i), 64'(o_col), 64'(tbl[i].col));
        chk($sformatf("vec%0d row", i), 64'(o_row), 64'(tbl[i].row));
        chk($sformatf("vec%0d data", i), 64'(o_data), 64'h10 + 64'(tbl[i].col));
      end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '1, 0);
      mcheck();
      advance();
    end
    rstn = 1'b0;
    #1;
    chk("midrst count", 64'(fifo_count), 64'd0);
    chk("midrst valid", 64'(o_valid), 64'd0);
    chk("midrst busy", 64'(rst_busy), 64'd1);
    chk("midrst ready", 64'(pe_ready), 64'd0);
    mreset();
    @(negedge clk);
    rstn = 1'b1;
    drive(0, 0, '1, 1);
    mcheck();
    advance();
    pend = '0;
    for (int n = 0; n < 500; n++) begin
      int g;
      bit fl;
      for (int i = 0; i < NC; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pe_data[i*PW +: PW] = PW'($urandom);
        end
      fl = $urandom_range(0, 29) == 0;
      drive(fl, RW'($urandom), pend, $urandom_range(0, 3) != 0);
      mcheck();
      g = mgrant(flush, pe_valid);
      advance();
      if (g >= 0) pend[g] = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psum_gather_ctrl.md
Name: psum_gather_ctrl

Overview:
- Return-path controller for one PE row: collects partial sums from the NUM_COL PEs on the row and serialises them toward the global buffer.
- Uses round-robin arbitration and a small tagged FIFO.
- The outbound handshake is valid/ready; the inbound side is a per-PE valid/ready.
- Each output word carries the latched row tag and the source column index, so the global buffer can route the result.

Parameters:
- DATA_WIDTH, 16, operand width; psum words are 2*DATA_WIDTH.
- NUM_COL, 4, number of PEs on the row (at least 2).
- NUM_ROW, 4, number of rows; sets the row-tag width RW = $clog2(NUM_ROW).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and arbiter; also latches row_id_in.
- rst_busy  out  1  high while the block is clearing.
- row_id_in  in  RW  row tag, sampled on flush.
- pe_psum_data_M2B  in  NUM_COL*2*DATA_WIDTH  flattened PE psums; PE i occupies bits [i*2*DATA_WIDTH +: 2*DATA_WIDTH].
- pe_psum_valid_M2B  in  NUM_COL  per-PE valid.
- pe_psum_ready_B2M  out  NUM_COL  per-PE ready, one-hot or zero.
- psum_data_B2G  out  2*DATA_WIDTH  head FIFO psum.
- psum_row_B2G  out  RW  head row tag.
- psum_col_B2G  out  $clog2(NUM_COL)  head source column.
- psum_valid_B2G  out  1  head entry valid.
- psum_ready_G2B  in  1  global buffer accepts.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values (rstn low):
  - FIFO empty, rd/wr pointers 0, fifo_count 0.
  - Arbiter pointer rr_ptr 0, row tag register 0.
  - rst_busy 1; psum_valid_B2G 0; pe_psum_ready_B2M all 0.
- rst_busy:
  - Registered.
  - Stays 1 for the first clk edge after rstn deasserts, then 0.
  - Also 1 for exactly the cycle after any cycle with flush=1.
  - While rst_busy=1, no grants are issued.
- Flush, on the clk edge with flush=1:
  - Pointers, count and rr_ptr go to 0; row tag <= row_id_in.
  - Any push or pop in that cycle is discarded; the handshake does not complete for either side.
  - pe_psum_ready_B2M is forced to 0 during flush.
- Arbitration (combinational grant):
  - Issued when not full, not flush, not rst_busy.
  - Search starts at rr_ptr and wraps modulo NUM_COL; the first i with pe_psum_valid_M2B[i]=1 gets pe_psum_ready_B2M[i]=1. All others get 0.
  - No valid inputs gives no grant, and rr_ptr holds.
- Push, on a clk edge with a grant:
  - The FIFO writes {row tag, i, PE i data}.
  - rr_ptr <= (i+1) mod NUM_COL; wraps from NUM_COL-1 to 0.
- Full handling:
  - When full, no grant is issued even if a pop happens in the same cycle.
  - This is a conservative, non-combinational ready path.
- Output:
  - First-word-fall-through: psum_valid_B2G = !empty.
  - Data, row and col show the head entry combinationally from FIFO storage.
  - Pop happens when psum_valid_B2G && psum_ready_G2B at the clk edge.
  - Head fields must stay stable while valid=1 and ready=0.
- Latency: PE handshake to psum_valid_B2G is 1 cycle when the FIFO was empty.
- Count: simultaneous push and pop leaves fifo_count unchanged. Push only adds 1; pop only subtracts 1. The count never exceeds FIFO_DEPTH and never goes below 0.
- Pointers: $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from fifo_count.
- PE contract: a PE holds valid and data until it sees ready; the block does not buffer unhandshaken inputs.
- Reset mid-operation: asynchronous clear to the reset values above; FIFO contents are lost.
- Throughput: one push and one pop per cycle maximum. Sustained 1 word/cycle when psum_ready_G2B=1.

Test Plan:
- Reset → rst_busy=1 during reset and for one cycle after release; all ready=0, valid_B2G=0, fifo_count=0.
- flush with row_id_in=2, then all 4 PEs valid (data 0x0000_0010..0x0000_0013), psum_ready_G2B=1 → outputs in col order 0,1,2,3 on consecutive cycles, row=2, first valid 1 cycle after the first grant.
- Fairness: PE0 and PE2 held valid continuously, ready_G2B=1 → grants alternate 0,2,0,2. PE0 is never granted twice in a row.
- Backpressure: ready_G2B=0, all PEs valid → exactly 4 grants, then fifo_count=4 and ready=0000. The head stays stable; raising ready_G2B drains 4 words in order.
- Full with simultaneous pop: FIFO full, ready_G2B=1 for one cycle → no grant that cycle and count=3; a grant resumes the next cycle.
- Flush mid-stream with count=3 and row_id_in=1 → next cycle count=0, valid_B2G=0, rst_busy=1, rr_ptr=0. Subsequent words carry row=1.
